// File: rtl/memory_port_arbiter_if.sv
// CPU-side (fetch and load/store) and memory-side signals of the memory port arbiter.
// The arbiter uses the slave view; the CPU and memory models use the master view.
interface memory_port_arbiter_if;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        data_request;
    logic [31:0] data_address;
    logic [1:0]  data_size;
    logic        data_write_enable;
    logic [31:0] data_write_value;
    logic        data_ready;
    logic [31:0] data_read_value;
    logic        bus_error;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_address;
    logic [1:0]  mem_size;
    logic        mem_write_enable;
    logic [31:0] mem_write_value;
    logic        mem_ack;
    logic [31:0] mem_read_value;

    modport slave (
        input  fetch_request, fetch_address, data_request, data_address, data_size,
               data_write_enable, data_write_value, mem_ack, mem_read_value,
        output fetch_ready, fetch_data, data_ready, data_read_value, bus_error, cpu_stall,
               mem_req, mem_address, mem_size, mem_write_enable, mem_write_value
    );

    modport master (
        output fetch_request, fetch_address, data_request, data_address, data_size,
               data_write_enable, data_write_value, mem_ack, mem_read_value,
        input  fetch_ready, fetch_data, data_ready, data_read_value, bus_error, cpu_stall,
               mem_req, mem_address, mem_size, mem_write_enable, mem_write_value
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and
// load/store, with a wait-cycle timeout that completes the access with a bus error.
module memory_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TIMEOUT_WIDTH  = 7
) (
    input logic                  clock,
    input logic                  reset,
    memory_port_arbiter_if.slave bus
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAccess  = 2'd1;
    localparam logic [1:0] StRespond = 2'd2;

    localparam logic [TIMEOUT_WIDTH-1:0] CountLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]               state_q;
    logic                     grant_data_q;
    logic                     last_grant_data_q;
    logic                     error_q;
    logic [TIMEOUT_WIDTH-1:0] count_q;
    logic [31:0]              mem_address_q;
    logic [1:0]               mem_size_q;
    logic                     mem_write_enable_q;
    logic [31:0]              mem_write_value_q;
    logic [31:0]              fetch_data_q;
    logic [31:0]              data_read_value_q;

    logic        pick_data;
    logic [31:0] capture_value;

    // Data wins when alone, or on a tie when fetch was served last.
    assign pick_data = bus.data_request & (~bus.fetch_request | ~last_grant_data_q);

    // Stores and timeouts return zero.
    assign capture_value = (bus.mem_ack & ~mem_write_enable_q) ? bus.mem_read_value : 32'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q            <= StIdle;
            grant_data_q       <= 1'b0;
            last_grant_data_q  <= 1'b0;
            error_q            <= 1'b0;
            count_q            <= '0;
            mem_address_q      <= 32'd0;
            mem_size_q         <= 2'd0;
            mem_write_enable_q <= 1'b0;
            mem_write_value_q  <= 32'd0;
            fetch_data_q       <= 32'd0;
            data_read_value_q  <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.fetch_request | bus.data_request) begin
                        grant_data_q       <= pick_data;
                        mem_address_q      <= pick_data ? bus.data_address : bus.fetch_address;
                        mem_size_q         <= !pick_data ? 2'd2 :
                                              (bus.data_size == 2'd3) ? 2'd2 : bus.data_size;
                        mem_write_enable_q <= pick_data & bus.data_write_enable;
                        mem_write_value_q  <= pick_data ? bus.data_write_value : 32'd0;
                        count_q            <= '0;
                        error_q            <= 1'b0;
                        state_q            <= StAccess;
                    end
                end
                StAccess: begin
                    if (bus.mem_ack || count_q == CountLast) begin
                        error_q <= ~bus.mem_ack;
                        if (grant_data_q) data_read_value_q <= capture_value;
                        else              fetch_data_q      <= capture_value;
                        state_q <= StRespond;
                    end else begin
                        count_q <= count_q + TIMEOUT_WIDTH'(1);
                    end
                end
                StRespond: begin
                    last_grant_data_q <= grant_data_q;
                    state_q           <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mem_req          = (state_q == StAccess);
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_size         = mem_size_q;
    assign bus.mem_write_enable = mem_write_enable_q;
    assign bus.mem_write_value  = mem_write_value_q;

    assign bus.fetch_ready     = (state_q == StRespond) & ~grant_data_q;
    assign bus.data_ready      = (state_q == StRespond) & grant_data_q;
    assign bus.bus_error       = (state_q == StRespond) & error_q;
    assign bus.fetch_data      = fetch_data_q;
    assign bus.data_read_value = data_read_value_q;

    assign bus.cpu_stall = (bus.fetch_request & ~bus.fetch_ready) |
                           (bus.data_request & ~bus.data_ready);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed self-checking bench for memory_port_arbiter: arbitration, latency, timeout, reset.
module tb_memory_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    memory_port_arbiter_if bus ();

    memory_port_arbiter #(
        .TIMEOUT_CYCLES(64),
        .TIMEOUT_WIDTH (7)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.fetch_request     = 1'b0;
        bus.fetch_address     = 32'd0;
        bus.data_request      = 1'b0;
        bus.data_address      = 32'd0;
        bus.data_size         = 2'd0;
        bus.data_write_enable = 1'b0;
        bus.data_write_value  = 32'd0;
        bus.mem_ack           = 1'b0;
        bus.mem_read_value    = 32'd0;
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        tick();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.cpu_stall); end
        checks++; if ({bus.fetch_ready, bus.data_ready, bus.bus_error} !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", {bus.fetch_ready, bus.data_ready, bus.bus_error}); end
        checks++; if (bus.mem_address !== 32'd0 || bus.fetch_data !== 32'd0 || bus.data_read_value !== 32'd0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", bus.mem_address, bus.fetch_data, bus.data_read_value); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch_one_wait();
        int req_cycles = 0;
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h100;
        tick();
        if (bus.mem_req) req_cycles++;
        checks++; if (bus.mem_address !== 32'h100 || bus.mem_size !== 2'd2) begin errors++; $display("FAIL fetch_latch got %h/%0d want 100/2", bus.mem_address, bus.mem_size); end
        tick();
        if (bus.mem_req) req_cycles++;
        bus.mem_ack        = 1'b1;
        bus.mem_read_value = 32'h00500093;
        tick();
        if (bus.mem_req) req_cycles++;
        checks++; if (req_cycles !== 2) begin errors++; $display("FAIL fetch_req_cycles got %0d want 2", req_cycles); end
        checks++; if (bus.fetch_ready !== 1'b1 || bus.fetch_data !== 32'h00500093) begin errors++; $display("FAIL fetch_ready got %b/%h want 1/00500093", bus.fetch_ready, bus.fetch_data); end
        checks++; if (bus.bus_error !== 1'b0 || bus.data_ready !== 1'b0) begin errors++; $display("FAIL fetch_err got %b/%b want 0/0", bus.bus_error, bus.data_ready); end
        bus.fetch_request = 1'b0;
        bus.mem_ack       = 1'b0;
        tick();
        checks++; if (bus.fetch_ready !== 1'b0 || bus.fetch_data !== 32'h00500093) begin errors++; $display("FAIL fetch_hold got %b/%h want 0/00500093", bus.fetch_ready, bus.fetch_data); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.fetch_request     = 1'b1;
        bus.fetch_address     = 32'h200;
        bus.data_request      = 1'b1;
        bus.data_address      = 32'h2000;
        bus.data_size         = 2'd2;
        bus.data_write_enable = 1'b1;
        bus.data_write_value  = 32'hDEADBEEF;
        tick();
        checks++; if (bus.mem_address !== 32'h2000 || bus.mem_write_enable !== 1'b1 || bus.mem_write_value !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_first got %h/%b/%h want 2000/1/deadbeef", bus.mem_address, bus.mem_write_enable, bus.mem_write_value); end
        bus.mem_ack        = 1'b1;
        bus.mem_read_value = 32'h55555555;
        tick();
        checks++; if (bus.data_ready !== 1'b1 || bus.fetch_ready !== 1'b0 || bus.data_read_value !== 32'd0) begin errors++; $display("FAIL rr_store_ready got %b/%b/%h want 1/0/0", bus.data_ready, bus.fetch_ready, bus.data_read_value); end
        bus.data_request = 1'b0;
        bus.mem_ack      = 1'b0;
        #1;
        checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL rr_stall_fetch got %b want 1", bus.cpu_stall); end
        tick();
        tick();
        checks++; if (bus.mem_address !== 32'h200 || bus.mem_write_enable !== 1'b0 || bus.mem_size !== 2'd2) begin errors++; $display("FAIL rr_second got %h/%b/%0d want 200/0/2", bus.mem_address, bus.mem_write_enable, bus.mem_size); end
        bus.mem_ack        = 1'b1;
        bus.mem_read_value = 32'h11111111;
        tick();
        checks++; if (bus.fetch_ready !== 1'b1 || bus.fetch_data !== 32'h11111111) begin errors++; $display("FAIL rr_fetch_ready got %b/%h want 1/11111111", bus.fetch_ready, bus.fetch_data); end
        // fetch keeps requesting and a load joins: tie after a fetch grant
        bus.mem_ack           = 1'b0;
        bus.data_request      = 1'b1;
        bus.data_address      = 32'h44;
        bus.data_write_enable = 1'b0;
        bus.data_write_value  = 32'd0;
        tick();
        tick();
        checks++; if (bus.mem_address !== 32'h44 || bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL rr_tie2 got %h/%b want 44/0", bus.mem_address, bus.mem_write_enable); end
        bus.mem_ack        = 1'b1;
        bus.mem_read_value = 32'hCAFEF00D;
        tick();
        checks++; if (bus.data_ready !== 1'b1 || bus.data_read_value !== 32'hCAFEF00D) begin errors++; $display("FAIL rr_load got %b/%h want 1/cafef00d", bus.data_ready, bus.data_read_value); end
        bus.data_request = 1'b0;
        bus.mem_ack      = 1'b0;
        tick();
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_address !== 32'h200) begin errors++; $display("FAIL rr_fetch_again got %b/%h want 1/200", bus.mem_req, bus.mem_address); end
        bus.mem_ack = 1'b1;
        tick();
        bus.fetch_request = 1'b0;
        bus.mem_ack       = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int  req_cycles = 0;
        bit  done = 1'b0;
        bus.data_request      = 1'b1;
        bus.data_address      = 32'h3;
        bus.data_size         = 2'd0;
        bus.data_write_enable = 1'b0;
        tick();
        checks++; if (bus.mem_address !== 32'h3 || bus.mem_size !== 2'd0) begin errors++; $display("FAIL to_latch got %h/%0d want 3/0", bus.mem_address, bus.mem_size); end
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.mem_req) req_cycles++;
            if (bus.data_ready) done = 1'b1;
            else tick();
        end
        checks++; if (!done) begin errors++; $display("FAIL to_done got 0 want 1"); end
        checks++; if (req_cycles !== 64) begin errors++; $display("FAIL to_req_cycles got %0d want 64", req_cycles); end
        checks++; if (bus.bus_error !== 1'b1 || bus.data_read_value !== 32'd0) begin errors++; $display("FAIL to_error got %b/%h want 1/0", bus.bus_error, bus.data_read_value); end
        bus.data_request = 1'b0;
        tick();
        checks++; if (bus.bus_error !== 1'b0) begin errors++; $display("FAIL to_error_pulse got %b want 0", bus.bus_error); end
    endtask

    task automatic test_reset_mid_access();
        int pulses = 0;
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h400;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_pre got %b/%b want 1/1", bus.mem_req, bus.cpu_stall); end
        // the CPU is reset alongside and withdraws its request
        reset             = 1'b1;
        bus.fetch_request = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_drop got %b/%b want 0/0", bus.mem_req, bus.cpu_stall); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.fetch_ready | bus.data_ready) pulses++;
            if (i == 1) reset = 1'b0;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_ready got %0d want 0", pulses); end
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h500;
        bus.data_request  = 1'b1;
        bus.data_address  = 32'h600;
        bus.data_size     = 2'd2;
        tick();
        checks++; if (bus.mem_address !== 32'h600) begin errors++; $display("FAIL rst_tie got %h want 600", bus.mem_address); end
        bus.mem_ack = 1'b1;
        tick();
        bus.data_request = 1'b0;
        bus.mem_ack      = 1'b0;
        tick();
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.fetch_request = 1'b0;
        bus.mem_ack       = 1'b0;
        tick();
    endtask

    task automatic test_spurious_ack();
        bus.mem_ack        = 1'b1;
        bus.mem_read_value = 32'h12345678;
        tick();
        checks++; if (bus.mem_req !== 1'b0 || bus.fetch_ready !== 1'b0 || bus.data_ready !== 1'b0) begin errors++; $display("FAIL sp_ignored got %b/%b/%b want 0/0/0", bus.mem_req, bus.fetch_ready, bus.data_ready); end
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h300;
        #1;
        checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL sp_stall0 got %b want 1", bus.cpu_stall); end
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.fetch_ready !== 1'b0 || bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL sp_cycle1 got %b/%b/%b want 1/0/1", bus.mem_req, bus.fetch_ready, bus.cpu_stall); end
        tick();
        checks++; if (bus.fetch_ready !== 1'b1 || bus.fetch_data !== 32'h12345678 || bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL sp_ready got %b/%h/%b want 1/12345678/0", bus.fetch_ready, bus.fetch_data, bus.cpu_stall); end
        bus.fetch_request = 1'b0;
        bus.mem_ack       = 1'b0;
        tick();
        checks++; if (bus.fetch_ready !== 1'b0 || bus.fetch_data !== 32'h12345678 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL sp_after got %b/%h/%b want 0/12345678/0", bus.fetch_ready, bus.fetch_data, bus.mem_req); end
    endtask

    initial begin
        test_reset();
        test_fetch_one_wait();
        test_round_robin();
        test_timeout();
        test_reset_mid_access();
        test_spurious_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
